// File: rtl/des_sched.sv
// Round-robin scheduler that shares one pipelined DES core among NUM_REQ requesters.
// Tags follow each operation through the core, and results return in order through an FWFT FIFO.
module des_sched #(
  parameter int NUM_REQ    = 4,
  parameter int CORE_LAT   = 19,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [64*NUM_REQ-1:0]      req_data,
  input  logic [64*NUM_REQ-1:0]      req_key,
  input  logic [NUM_REQ-1:0]         req_mode,
  output logic                       core_valid_in,
  output logic [63:0]                core_plain_text,
  output logic [63:0]                core_cipher_key,
  output logic                       core_encrypt_decrypt,
  input  logic                       core_valid_out,
  input  logic [63:0]                core_cipher_text,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [63:0]                rsp_data,
  output logic                       busy,
  output logic                       err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 2;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t           state_r;
  logic             cur_mode_r;
  logic             pend_mode_r;
  logic [IDW-1:0]   rr_ptr_r;
  logic [CW-1:0]    inflight_r;
  logic [CW-1:0]    fifo_count_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CORE_LAT-1:0] tag_v_r;
  logic [IDW-1:0]   tag_id_r [CORE_LAT];
  logic [IDW+63:0]  mem_r [FIFO_DEPTH];
  logic             err_r;

  logic [63:0]      data_a_s [NUM_REQ];
  logic [63:0]      key_a_s  [NUM_REQ];
  logic [IDW-1:0]   cand_s;
  logic             found_s;
  logic             has_credit_s;
  logic             issue_s;
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             dec_s;
  logic             tag_em_s;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign data_a_s[g] = req_data[64*g +: 64];
    assign key_a_s[g]  = req_key[64*g +: 64];
  end

  // First valid requester at or after rr_ptr; scanning backwards lets the nearest one win.
  always_comb begin : cand_sel
    int j;
    logic [IDW-1:0] idx;
    cand_s  = '0;
    found_s = 1'b0;
    j       = 0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j   = (int'(rr_ptr_r) + k >= NUM_REQ) ? int'(rr_ptr_r) + k - NUM_REQ : int'(rr_ptr_r) + k;
      idx = IDW'(j);
      if (req_valid[idx]) begin
        cand_s  = idx;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign empty_s      = (fifo_count_r == '0);
  assign full_s       = (fifo_count_r == CW'(FIFO_DEPTH));
  assign pop_s        = !empty_s && rsp_ready;
  assign push_s       = core_valid_out && (!full_s || pop_s);
  assign dec_s        = core_valid_out && (inflight_r != '0);
  assign tag_em_s     = tag_v_r[CORE_LAT-1];
  assign has_credit_s = (fifo_count_r + inflight_r) < CW'(FIFO_DEPTH);
  assign issue_s      = rstn && (state_r == RUN) && found_s &&
                        (req_mode[cand_s] == cur_mode_r) && has_credit_s;

  // Issue path to the core: one-hot accept plus the winner's text and key, zero otherwise.
  always_comb begin
    req_ready       = '0;
    core_valid_in   = 1'b0;
    core_plain_text = 64'h0;
    core_cipher_key = 64'h0;
    if (issue_s) begin
      req_ready[cand_s] = 1'b1;
      core_valid_in     = 1'b1;
      core_plain_text   = data_a_s[cand_s];
      core_cipher_key   = key_a_s[cand_s];
    end else begin
      core_valid_in     = 1'b0;
    end
  end

  assign core_encrypt_decrypt = cur_mode_r;
  assign rsp_valid            = rstn && !empty_s;
  assign {rsp_id, rsp_data}   = rsp_valid ? mem_r[rd_ptr_r] : {(IDW + 64){1'b0}};
  assign busy                 = rstn && ((inflight_r != '0) || !empty_s);
  assign err                  = rstn && err_r;

  // Mode FSM, round-robin pointer, inflight accounting and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= RUN;
      cur_mode_r  <= 1'b0;
      pend_mode_r <= 1'b0;
      rr_ptr_r    <= '0;
      inflight_r  <= '0;
      err_r       <= 1'b0;
    end else begin
      if (issue_s) begin
        rr_ptr_r <= (cand_s == IDW'(NUM_REQ - 1)) ? '0 : cand_s + IDW'(1);
      end
      case (state_r)
        RUN: begin
          if (found_s && (req_mode[cand_s] != cur_mode_r)) begin
            state_r     <= DRAIN;
            pend_mode_r <= req_mode[cand_s];
          end
        end
        DRAIN: begin
          // Mode may only flip once the core pipeline is empty; queued results are unaffected.
          if (inflight_r == '0) begin
            cur_mode_r <= pend_mode_r;
            state_r    <= RUN;
          end
        end
        default: state_r <= RUN;
      endcase
      case ({issue_s, dec_s})
        2'b10:   inflight_r <= inflight_r + CW'(1);
        2'b01:   inflight_r <= inflight_r - CW'(1);
        default: inflight_r <= inflight_r;
      endcase
      err_r <= err_r | (core_valid_out & ~tag_em_s) | (tag_em_s & ~core_valid_out) |
               (core_valid_out & full_s & ~pop_s);
    end
  end

  // Tag pipeline mirroring the core latency; the last stage lines up with core_valid_out.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < CORE_LAT; i++) begin
        tag_v_r[i]  <= 1'b0;
        tag_id_r[i] <= '0;
      end
    end else begin
      for (int i = CORE_LAT - 1; i > 0; i--) begin
        tag_v_r[i]  <= tag_v_r[i-1];
        tag_id_r[i] <= tag_id_r[i-1];
      end
      tag_v_r[0]  <= issue_s;
      tag_id_r[0] <= cand_s;
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      fifo_count_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + CW'(1);
        2'b01:   fifo_count_r <= fifo_count_r - CW'(1);
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  // Response FIFO storage.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {tag_id_r[CORE_LAT-1], core_cipher_text};
    end
  end

endmodule

// File: tb/tb_des_sched.sv
// Directed bench for des_sched with a behavioural fixed-latency core.
// The core stand-in knows the one published DES vector and uses a simple mix for other inputs.
module tb_des_sched;
  localparam int NR  = 4;
  localparam int LAT = 19;
  localparam int FD  = 8;
  localparam logic [63:0] K = 64'h133457799BBCDFF1;
  localparam logic [63:0] P = 64'h0123456789ABCDEF;
  localparam logic [63:0] C = 64'h85E813540F0AB405;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [64*NR-1:0] req_data = '0;
  logic [64*NR-1:0] req_key = '0;
  logic [NR-1:0]   req_mode = '0;
  logic            core_valid_in;
  logic [63:0]     core_plain_text;
  logic [63:0]     core_cipher_key;
  logic            core_encrypt_decrypt;
  logic            core_valid_out;
  logic [63:0]     core_cipher_text;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [1:0]      rsp_id;
  logic [63:0]     rsp_data;
  logic            busy;
  logic            err;
  logic            inject = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  des_sched #(.NUM_REQ(NR), .CORE_LAT(LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_key(req_key), .req_mode(req_mode),
    .core_valid_in(core_valid_in), .core_plain_text(core_plain_text),
    .core_cipher_key(core_cipher_key), .core_encrypt_decrypt(core_encrypt_decrypt),
    .core_valid_out(core_valid_out), .core_cipher_text(core_cipher_text),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy), .err(err)
  );

  function automatic logic [63:0] des_model(input logic [63:0] d, input logic [63:0] k, input logic m);
    if (k == K && d == P && !m) return C;
    if (k == K && d == C && m) return P;
    return d ^ k ^ {64{m}} ^ 64'hA5A5_5A5A_0F0F_F0F0;
  endfunction

  function automatic logic [63:0] data_of(input int i);
    return {32'hDA7A_0000, 28'h0, 4'(i)};
  endfunction

  function automatic logic [63:0] key_of(input int i);
    return {32'hC0FF_EE00, 24'h0, 8'(i * 17)};
  endfunction

  // Core stand-in: fixed CORE_LAT pipeline, reset together with the scheduler.
  logic [LAT-1:0] pv;
  logic [63:0]    pd [LAT];
  logic [63:0]    pk [LAT];
  logic           pm [LAT];
  always @(posedge clk) begin
    if (!rstn) pv <= '0;
    else pv <= {pv[LAT-2:0], core_valid_in};
    for (int i = LAT - 1; i > 0; i--) begin
      pd[i] <= pd[i-1]; pk[i] <= pk[i-1]; pm[i] <= pm[i-1];
    end
    pd[0] <= core_plain_text; pk[0] <= core_cipher_key; pm[0] <= core_encrypt_decrypt;
  end
  assign core_valid_out   = pv[LAT-1] | inject;
  assign core_cipher_text = pv[LAT-1] ? des_model(pd[LAT-1], pk[LAT-1], pm[LAT-1]) : 64'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_slice(input int i, input logic [63:0] d, input logic [63:0] k);
    req_data[i*64 +: 64] = d;
    req_key[i*64 +: 64]  = k;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'h0);
    chk({tag, "_cvi"},   64'(core_valid_in), 64'h0);
    chk({tag, "_cpt"},   core_plain_text, 64'h0);
    chk({tag, "_ckey"},  core_cipher_key, 64'h0);
    chk({tag, "_ced"},   64'(core_encrypt_decrypt), 64'h0);
    chk({tag, "_rsp"},   {60'h0, rsp_valid, busy, err, 1'b0}, 64'h0);
    chk({tag, "_rid"},   64'(rsp_id), 64'h0);
    chk({tag, "_rdata"}, rsp_data, 64'h0);
  endtask

  task automatic do_reset();
    #1;
    rstn = 1'b0; req_valid = '0; req_mode = '0; rsp_ready = 1'b0; inject = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); check_idle("in_reset");
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk); check_idle("after_reset");
  endtask

  task automatic get_rsp(input string tag, input int exp_id, input logic [63:0] exp_d);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, 64'(rsp_valid), 64'h1);
    if (rsp_valid) begin
      chk({tag, "_id"}, 64'(rsp_id), 64'(exp_id));
      chk({tag, "_data"}, rsp_data, exp_d);
      rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
    end
  endtask

  task automatic count_issues(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (core_valid_in) c++;
    end
  endtask

  task automatic run_single(input string tag);
    int n;
    @(posedge clk); #1;
    set_slice(0, P, K); req_mode = 4'b0000; req_valid = 4'b0001;
    @(negedge clk);
    chk({tag, "_issue"}, 64'(core_valid_in), 64'h1);
    chk({tag, "_ready"}, 64'(req_ready), 64'h1);
    chk({tag, "_text"}, core_plain_text, P);
    chk({tag, "_key"}, core_cipher_key, K);
    @(posedge clk); #1 req_valid = 4'b0000; n = 1;
    @(negedge clk);
    chk({tag, "_busy"}, 64'(busy), 64'h1);
    while (!rsp_valid && n < 100) begin @(posedge clk); n++; @(negedge clk); end
    chk({tag, "_latency"}, 64'(n), 64'(LAT + 1));
    get_rsp(tag, 0, C);
    @(negedge clk);
    chk({tag, "_idle"}, 64'(busy), 64'h0);
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] mode;
    logic [NR-1:0] exp_ready;
  } vec_t;

  vec_t vt [11];
  int   exp_q [$];

  initial begin
    int n, c, id;
    vt[0]  = '{4'b0000, 4'b0000, 4'b0000};
    vt[1]  = '{4'b0100, 4'b0000, 4'b0100};
    vt[2]  = '{4'b0101, 4'b0000, 4'b0001};
    vt[3]  = '{4'b0101, 4'b0000, 4'b0100};
    vt[4]  = '{4'b1000, 4'b0000, 4'b1000};
    vt[5]  = '{4'b1111, 4'b0000, 4'b0001};
    vt[6]  = '{4'b1111, 4'b0000, 4'b0010};
    vt[7]  = '{4'b1111, 4'b0000, 4'b0100};
    vt[8]  = '{4'b1111, 4'b0000, 4'b1000};
    vt[9]  = '{4'b1111, 4'b0000, 4'b0000};
    vt[10] = '{4'b1111, 4'b0000, 4'b0000};

    do_reset();

    // Round-robin order and credit stall after eight outstanding operations.
    for (int i = 0; i < NR; i++) set_slice(i, data_of(i), key_of(i));
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      req_valid = vt[i].valid; req_mode = vt[i].mode;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(vt[i].exp_ready));
      chk($sformatf("vec%0d_cvi", i), 64'(core_valid_in), 64'(|vt[i].exp_ready));
      if (vt[i].exp_ready != 4'b0000) begin
        id = 0;
        for (int b = 0; b < NR; b++) if (vt[i].exp_ready[b]) id = b;
        chk($sformatf("vec%0d_text", i), core_plain_text, data_of(id));
        chk($sformatf("vec%0d_key", i), core_cipher_key, key_of(id));
        exp_q.push_back(id);
      end
    end
    @(posedge clk); #1 req_valid = '0;
    while (exp_q.size() > 0) begin
      id = exp_q.pop_front();
      get_rsp("rr_rsp", id, des_model(data_of(id), key_of(id), 1'b0));
    end
    @(negedge clk);
    chk("rr_err", 64'(err), 64'h0);

    // Known-answer single request with minimum latency.
    do_reset();
    run_single("single");

    // Mode switch drains the core before the decrypt issues.
    do_reset();
    @(posedge clk); #1;
    set_slice(1, P, K); req_mode = 4'b0000; req_valid = 4'b0010;
    @(negedge clk);
    chk("ms_first_ready", 64'(req_ready), 64'h2);
    chk("ms_first_mode", 64'(core_encrypt_decrypt), 64'h0);
    @(posedge clk); #1;
    set_slice(2, C, K); req_mode = 4'b0100; req_valid = 4'b0100;
    n = 0;
    @(negedge clk);
    while (!core_valid_in && n < 100) begin n++; @(negedge clk); end
    chk("ms_drain_gap", 64'(n >= LAT), 64'h1);
    chk("ms_issue", 64'(core_valid_in), 64'h1);
    chk("ms_mode", 64'(core_encrypt_decrypt), 64'h1);
    chk("ms_ready", 64'(req_ready), 64'h4);
    chk("ms_text", core_plain_text, C);
    @(posedge clk); #1 req_valid = '0;
    get_rsp("ms_enc", 1, C);
    get_rsp("ms_dec", 2, P);

    // Backpressure: FIFO_DEPTH issues, then one issue per pop.
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) set_slice(i, data_of(i), key_of(i));
    req_mode = 4'b0000; req_valid = 4'b1111;
    count_issues(60, c);
    chk("bp_issues", 64'(c), 64'(FD));
    @(negedge clk);
    chk("bp_stalled", 64'(req_ready), 64'h0);
    chk("bp_busy", 64'(busy), 64'h1);
    get_rsp("bp_pop0", 0, des_model(data_of(0), key_of(0), 1'b0));
    count_issues(40, c);
    chk("bp_resume0", 64'(c), 64'h1);
    get_rsp("bp_pop1", 1, des_model(data_of(1), key_of(1), 1'b0));
    count_issues(40, c);
    chk("bp_resume1", 64'(c), 64'h1);
    chk("bp_err", 64'(err), 64'h0);

    // Spurious core result sets the sticky error.
    do_reset();
    chk("inj_pre", 64'(err), 64'h0);
    @(posedge clk); #1 inject = 1'b1;
    @(posedge clk); #1 inject = 1'b0;
    @(negedge clk);
    chk("inj_set", 64'(err), 64'h1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("inj_sticky", 64'(err), 64'h1);

    // Reset with five operations in flight, then a normal request.
    do_reset();
    @(posedge clk); #1;
    set_slice(0, data_of(0), key_of(0)); req_mode = 4'b0000; req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("mf_issue%0d", i), 64'(core_valid_in), 64'h1);
      @(posedge clk);
    end
    do_reset();
    run_single("mf_after");
    chk("mf_err", 64'(err), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
